// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered WIDTH-bit ALU with valid/ready handshakes, persistent carry and optional iterative multiply
// Optional feature macro: ALU_MUL_EN (iterative shift-add MUL on opcode 14; otherwise opcode 14 yields zero)
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             sign,
  output logic             cflag
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_INC = 4'd2,  OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11;
  localparam logic [3:0] OP_ADC = 4'd12, OP_SBC = 4'd13, OP_MUL = 4'd14, OP_CMP = 4'd15;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE     = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   ALL_ONE = {1'b0, {WIDTH{1'b1}}};

  // output register can take a new value this cycle
  logic free;
  logic accept;
  assign free   = !out_valid || out_ready;
  assign accept = in_valid && in_ready;

  logic [WIDTH:0]   ext_a, ext_b, ext_nb, cin, sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;
  // ops 4-7 leave the persistent carry alone
  logic             cf_upd;
  assign cf_upd = (opcode[3:2] != 2'b01);

  // single-cycle operation results and flags
  always_comb begin
    ext_a  = {1'b0, a};
    ext_b  = {1'b0, b};
    ext_nb = {1'b0, ~b};
    cin    = {{WIDTH{1'b0}}, cflag};
    sum    = '0;
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        sum   = ext_a + ext_b + ((opcode == OP_ADC) ? cin : '0);
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP, OP_SBC: begin
        sum   = ext_a + ext_nb + ((opcode == OP_SBC) ? cin : ONE);
        alu_r = (opcode == OP_CMP) ? a : sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        sum   = ext_a + ONE;
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a == MAX_POS);
      end
      OP_DEC: begin
        sum   = ext_a + ALL_ONE;
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a == MIN_NEG);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_NOT: alu_r = ~a;
      OP_SHL: begin alu_r = {a[WIDTH-2:0], 1'b0};       alu_c = a[WIDTH-1]; end
      OP_SHR: begin alu_r = {1'b0, a[WIDTH-1:1]};       alu_c = a[0];       end
      OP_ROL: begin alu_r = {a[WIDTH-2:0], a[WIDTH-1]}; alu_c = a[WIDTH-1]; end
      OP_ROR: begin alu_r = {a[0], a[WIDTH-1:1]};       alu_c = a[0];       end
      OP_MUL: alu_r = '0;
      default: alu_r = '0;
    endcase
  end

  logic             load_en;
  logic [WIDTH-1:0] load_r;
  logic             load_c, load_v, load_cf;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_t;
  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_next, mcand, prod;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mul_done;

  assign in_ready = (state == S_IDLE) && free;
  assign prod     = (state == S_MUL) ? acc_next : acc;
  assign mul_done = ((state == S_MUL) && (cnt == '0) && free) || ((state == S_WAIT) && free);

  // next state and the shift-add step of the multiplier
  always_comb begin
    state_nx = state;
    acc_next = acc + (mplier[0] ? mcand : '0);
    case (state)
      S_IDLE:  if (accept && opcode == OP_MUL) state_nx = S_MUL;
      S_MUL:   if (cnt == '0) state_nx = free ? S_IDLE : S_WAIT;
      S_WAIT:  if (free) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state and multiplier datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && accept && opcode == OP_MUL) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= CNT_W'(WIDTH-1);
      end else if (state == S_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
      end
    end
  end

  // select what goes into the output register: finished product or single-cycle result
  always_comb begin
    load_en = 1'b0;
    load_r  = alu_r;
    load_c  = alu_c;
    load_v  = alu_v;
    load_cf = cf_upd;
    if (mul_done) begin
      load_en = 1'b1;
      load_r  = prod[WIDTH-1:0];
      load_c  = |prod[2*WIDTH-1:WIDTH];
      load_v  = 1'b0;
      load_cf = 1'b1;
    end else if (accept && opcode != OP_MUL) begin
      load_en = 1'b1;
    end
  end
`else
  assign in_ready = free;

  // every accepted op completes in one cycle
  always_comb begin
    load_en = accept;
    load_r  = alu_r;
    load_c  = alu_c;
    load_v  = alu_v;
    load_cf = cf_upd;
  end
`endif

  // output register, held while downstream stalls; cflag follows each loading carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      sign      <= 1'b0;
      cflag     <= 1'b0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      result    <= load_r;
      zero      <= (load_r == '0);
      carry     <= load_c;
      overflow  <= load_v;
      sign      <= load_r[WIDTH-1];
      if (load_cf) cflag <= load_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;

  localparam int W8 = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, ir, ov, ordy;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  op8;
  logic        z8, c8, v8, s8, cf8;

  logic        iv16, ir16, ov16, ordy16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  op16;
  logic        z16, c16, v16, s16, cf16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a8), .b(b8), .opcode(op8),
    .out_valid(ov), .out_ready(ordy), .result(res8), .zero(z8), .carry(c8), .overflow(v8),
    .sign(s8), .cflag(cf8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .opcode(op16),
    .out_valid(ov16), .out_ready(ordy16), .result(res16), .zero(z16), .carry(c16), .overflow(v16),
    .sign(s16), .cflag(cf16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: plain integer arithmetic with signed range test for overflow
  function automatic void ref_op(input int w, input int op, input longint x, input longint y,
                                 input bit cfi, output longint r, output bit c, output bit v);
    longint m, h, sx, sy, s, full;
    bit arith;
    m = (64'sd1 <<< w) - 1;
    h = 64'sd1 <<< (w-1);
    sx = (x >= h) ? x - 2*h : x;
    sy = (y >= h) ? y - 2*h : y;
    s = 0; full = 0; arith = 0; c = 0; r = 0;
    case (op)
      0:  begin full = x + y; s = sx + sy; c = full > m; r = full; arith = 1; end
      1, 15: begin full = x - y; s = sx - sy; c = x >= y; r = (op == 15) ? x : full; arith = 1; end
      2:  begin full = x + 1; s = sx + 1; c = full > m; r = full; arith = 1; end
      3:  begin full = x - 1; s = sx - 1; c = x != 0; r = full; arith = 1; end
      4:  r = x & y;
      5:  r = x | y;
      6:  r = x ^ y;
      7:  r = ~x;
      8:  begin r = x << 1; c = (x >> (w-1)) & 1; end
      9:  begin r = x >> 1; c = x & 1; end
      10: begin r = (x << 1) | (x >> (w-1)); c = (x >> (w-1)) & 1; end
      11: begin r = (x >> 1) | ((x & 1) << (w-1)); c = x & 1; end
      12: begin full = x + y + cfi; s = sx + sy + cfi; c = full > m; r = full; arith = 1; end
      13: begin full = x - y - 1 + cfi; s = sx - sy - 1 + cfi; c = full >= 0; r = full; arith = 1; end
      default: begin
`ifdef ALU_MUL_EN
        full = x * y; r = full; c = (full >> w) != 0;
`else
        r = 0; c = 0;
`endif
      end
    endcase
    r = r & m;
    v = arith && (s > h - 1 || s < -h);
  endfunction

  typedef struct {
    longint r;
    bit     c;
    bit     v;
    bit     cf;
    bit     is_mul;
  } exp_t;

  exp_t       sbq[$];
  bit         mcf = 0;
  bit         pend = 0;
  int         age = 0;
  bit         prev_hold = 0;
  logic [12:0] held;

  // scoreboard: model every accept, compare every consumed output, watch handshake and hold
  always @(negedge clk) begin
    longint r;
    bit c, v;
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      mcf = 0; pend = 0; age = 0; prev_hold = 0;
    end else begin
      if (pend) age++;
      if (pend && age >= 1 && age <= W8) chk("ready_mul_busy", ir, 0);
      else if (!pend) chk("ready_rule", ir, (!ov) || ordy);
      if (prev_hold) chk("hold_stable", {ov, res8, z8, c8, v8, s8}, held);
      prev_hold = ov && !ordy;
      held = {ov, res8, z8, c8, v8, s8};
      if (ov && ordy) begin
        if (sbq.size() == 0) chk("stray_out_valid", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("result", res8, e.r);
          chk("zero", z8, e.r == 0);
          chk("carry", c8, e.c);
          chk("overflow", v8, e.v);
          chk("sign", s8, (e.r >> 7) & 1);
          chk("cflag", cf8, e.cf);
          if (e.is_mul) pend = 0;
        end
      end
      if (iv && ir) begin
        ref_op(8, int'(op8), longint'(a8), longint'(b8), mcf, r, c, v);
        if (op8 < 4 || op8 > 7) mcf = c;
        e.r = r; e.c = c; e.v = v; e.cf = mcf; e.is_mul = 0;
`ifdef ALU_MUL_EN
        if (op8 == 4'd14) begin e.is_mul = 1; pend = 1; age = 0; end
`endif
        sbq.push_back(e);
      end
    end
  end

  int last_wait;

  task automatic send(input int op, input int x, input int y);
    iv = 1; a8 = x[7:0]; b8 = y[7:0]; op8 = op[3:0];
    last_wait = 0;
    @(negedge clk);
    while (!ir && last_wait < 100) begin last_wait++; @(negedge clk); end
    if (!ir) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    iv = 0;
  endtask

  bit mcf16 = 0;

  task automatic do16(input int op, input int x, input int y);
    longint r;
    bit c, v;
    int n;
    iv16 = 1; a16 = x[15:0]; b16 = y[15:0]; op16 = op[3:0];
    n = 0;
    @(negedge clk);
    while (!ir16 && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    iv16 = 0;
    n = 0;
    while (!ov16 && n < 40) begin @(posedge clk); #1; n++; end
    chk("w16_valid", ov16, 1);
    ref_op(16, op, longint'(x), longint'(y), mcf16, r, c, v);
    if (op < 4 || op > 7) mcf16 = c;
    chk("w16_result", res16, r);
    chk("w16_zero", z16, r == 0);
    chk("w16_carry", c16, c);
    chk("w16_overflow", v16, v);
    chk("w16_sign", s16, (r >> 15) & 1);
    chk("w16_cflag", cf16, mcf16);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit any;
    rst_n = 0; iv = 0; ordy = 1; a8 = 0; b8 = 0; op8 = 0;
    iv16 = 0; ordy16 = 1; a16 = 0; b16 = 0; op16 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", res8, 0);
    chk("rst_flags", {z8, c8, v8, s8}, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_cflag", cf8, 0);
    chk("rst16_all", {ov16, res16, z16, c16, v16, s16, cf16}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", ir, 1);

    send(0, 'h7F, 'h01);
    chk("add7f_valid", ov, 1);
    chk("add7f_result", res8, 'h80);
    chk("add7f_szvc", {s8, z8, v8, c8}, 4'b1010);

    send(0, 'hFF, 'h01);
    chk("addff_result", res8, 'h00);
    chk("addff_zc", {z8, c8}, 2'b11);
    send(12, 'h00, 'h00);
    chk("adc_result", res8, 'h01);
    chk("adc_c_cf", {c8, cf8}, 2'b00);
    send(1, 'h00, 'h01);
    chk("sub_result", res8, 'hFF);
    chk("sub_carry", c8, 0);
    send(13, 'h05, 'h01);
    chk("sbc_result", res8, 'h03);

    send(14, 'h10, 'h10);
`ifdef ALU_MUL_EN
    n = 0;
    while (!ov && n < 50) begin @(posedge clk); #1; n++; end
    chk("mul_latency", n, W8);
    chk("mul_result", res8, 'h00);
    chk("mul_cz", {c8, z8}, 2'b11);
`else
    chk("mul_off_valid", ov, 1);
    chk("mul_off_result", res8, 'h00);
    chk("mul_off_zc_cf", {z8, c8, cf8}, 3'b100);
`endif

    send(4, 'hF0, 'h3C);
    ordy = 0;
    chk("bp_result", res8, 'h30);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_result", res8, 'h30);
      chk("bp_hold_valid", ov, 1);
      chk("bp_in_ready", ir, 0);
    end
    ordy = 1;
    send(5, 'h01, 'h02);
    chk("bp_same_cycle_accept", last_wait, 0);
    chk("bp_next_result", res8, 'h03);

    send(0, 'hFF, 'h01);
    send(14, 'h03, 'h05);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    chk("mrst_outputs", {ov, res8, z8, c8, v8, s8}, 0);
    chk("mrst_cflag", cf8, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    any = 0;
    repeat (20) begin @(posedge clk); #1; any |= ov; end
    chk("mrst_no_stray_valid", any, 0);
    chk("mrst_in_ready", ir, 1);

    repeat (2000) begin
      @(posedge clk); #1;
      iv   = ($urandom_range(0, 3) != 0);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      op8  = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv = 0; ordy = 1;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", sbq.size(), 0);

    do16(10, 'h8001, 0);
    chk("rol16_const", {res16, c16}, {16'h0003, 1'b1});
    do16(9, 'h0001, 0);
    chk("shr16_const", {res16, c16, z16}, {16'h0000, 1'b1, 1'b1});
    do16(15, 'h1234, 'h1234);
    chk("cmp16_const", {res16, z16, c16}, {16'h1234, 1'b0, 1'b1});
    repeat (40) do16($urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 65535));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
